guess_evaluator: RTL and testbench

Scores a submitted five-letter Wordle guess against the hidden answer and returns the colored row in the same 7-bit-per-cell packing the letter-entry stage uses. It consumes the entry stage's one-cycle `submitted` pulse and the assembled row letters, and runs a two-pass green/yellow algorithm that handles duplicate letters. It tracks the guess count and win/game-over status. The packed result goes to the board store and display.

---
 rtl/wordle_pkg.sv | 30 +++
 rtl/guess_evaluator_if.sv | 28 ++
 rtl/letter_count_bank.sv | 38 +++
 rtl/guess_evaluator.sv | 163 ++++++++++++++++
 tb/tb_guess_evaluator.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wordle_pkg.sv
// Shared Wordle definitions: colour codes, cell/letter packing widths,
// evaluator FSM states and a helper to pull one letter out of a packed word.
package wordle_pkg;

  localparam int unsigned LETTER_W    = 5;
  localparam int unsigned CELL_W      = 7;
  localparam int unsigned NUM_COLS    = 5;
  localparam int unsigned NUM_LETTERS = 26;
  localparam int unsigned BLANK       = 26;
  localparam int unsigned WORD_W      = LETTER_W * NUM_COLS;
  localparam int unsigned ROW_W       = CELL_W * NUM_COLS;

  localparam logic [1:0] GREY   = 2'd0;
  localparam logic [1:0] YELLOW = 2'd1;
  localparam logic [1:0] GREEN  = 2'd2;
  localparam logic [1:0] RED    = 2'd3;

  typedef enum logic [1:0] {
    IDLE,
    GREEN_PASS,
    YELLOW_PASS,
    DONE
  } state_t;

  function automatic logic [LETTER_W-1:0] letter_at(input logic [WORD_W-1:0] word,
                                                    input logic [2:0] idx);
    return word[LETTER_W*idx +: LETTER_W];
  endfunction

endpackage

// File: rtl/guess_evaluator_if.sv
// Evaluator bus: guess/answer submission in, coloured row and game status out.
//   master: drives new_game, submit, guess, answer (letter-entry side)
//   slave : the evaluator, drives result, row, busy, done, reject, win, game_over
interface guess_evaluator_if;

  logic                              new_game;
  logic                              submit;
  logic [wordle_pkg::WORD_W-1:0]     guess;
  logic [wordle_pkg::WORD_W-1:0]     answer;
  logic [wordle_pkg::ROW_W-1:0]      result;
  logic [2:0]                        row;
  logic                              busy;
  logic                              done;
  logic                              reject;
  logic                              win;
  logic                              game_over;

  modport master (
    output new_game, submit, guess, answer,
    input  result, row, busy, done, reject, win, game_over
  );

  modport slave (
    input  new_game, submit, guess, answer,
    output result, row, busy, done, reject, win, game_over
  );

endinterface

// File: rtl/letter_count_bank.sv
// 26 x 3-bit letter counters used to track unmatched answer letters.
//   clk, rst          : clock, synchronous active-high reset
//   clr               : clear all counters
//   inc, inc_idx      : increment counter inc_idx (saturates at 5)
//   dec, dec_idx      : decrement counter dec_idx (floors at 0)
//   rd_idx, nonzero   : combinational read, count[rd_idx] > 0
module letter_count_bank
  import wordle_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                inc,
  input  logic [LETTER_W-1:0] inc_idx,
  input  logic                dec,
  input  logic [LETTER_W-1:0] dec_idx,
  input  logic [LETTER_W-1:0] rd_idx,
  output logic                nonzero
);

  localparam logic [LETTER_W-1:0] LAST_LETTER = LETTER_W'(NUM_LETTERS - 1);

  logic [2:0] cnt [NUM_LETTERS];

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      for (int unsigned i = 0; i < NUM_LETTERS; i++) cnt[i] <= '0;
    end else begin
      if (inc && inc_idx <= LAST_LETTER && cnt[inc_idx] < 3'd5)
        cnt[inc_idx] <= cnt[inc_idx] + 3'd1;
      if (dec && dec_idx <= LAST_LETTER && cnt[dec_idx] != '0)
        cnt[dec_idx] <= cnt[dec_idx] - 3'd1;
    end
  end

  assign nonzero = (rd_idx <= LAST_LETTER) ? (cnt[rd_idx] != '0) : 1'b0;

endmodule

// File: rtl/guess_evaluator.sv
// Scores a five-letter guess against the answer with the two-pass
// green/yellow algorithm, one column per cycle per pass, and tracks
// guess count, win and game-over.
//   clk, rst : clock, synchronous active-high reset
//   bus      : guess_evaluator_if slave (submit/new_game in, result/status out)
// MAX_GUESSES must fit the 3-bit row/count (<= 7).
module guess_evaluator
  import wordle_pkg::*;
#(
  parameter int unsigned MAX_GUESSES = 6
) (
  input  logic              clk,
  input  logic              rst,
  guess_evaluator_if.slave  bus
);

  localparam logic [2:0] LAST_COL = 3'(NUM_COLS - 1);
  localparam logic [2:0] MAX_CNT  = 3'(MAX_GUESSES);

  state_t                   state, next_state;
  logic [WORD_W-1:0]        g_r, a_r;
  logic [2:0]               col;
  logic                     rej_r;
  logic [NUM_COLS-1:0]      green_mask;
  logic [2:0]               guess_cnt, next_cnt;
  logic [ROW_W-1:0]         result_r;
  logic [2:0]               row_r;
  logic                     done_r, reject_r, win_r, game_over_r;

  logic [LETTER_W-1:0]      g_col, a_col;
  logic                     col_match, hit, accept, bad_letter;
  logic                     clr, inc, dec;

  assign g_col     = letter_at(g_r, col);
  assign a_col     = letter_at(a_r, col);
  assign col_match = (g_col == a_col);
  assign accept    = bus.submit && !bus.new_game && !game_over_r;
  assign next_cnt  = (guess_cnt >= MAX_CNT - 3'd1) ? MAX_CNT : guess_cnt + 3'd1;

  always_comb begin
    bad_letter = 1'b0;
    for (int unsigned i = 0; i < NUM_COLS; i++)
      if (bus.guess[LETTER_W*i +: LETTER_W] > LETTER_W'(NUM_LETTERS - 1)) bad_letter = 1'b1;
  end

  letter_count_bank u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .inc     (inc),
    .inc_idx (a_col),
    .dec     (dec),
    .dec_idx (g_col),
    .rd_idx  (g_col),
    .nonzero (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // A rejected guess still passes through GREEN_PASS for one cycle, where
  // the RED row is written; this gives the reject path its fixed latency.
  always_comb begin
    next_state = state;
    clr        = 1'b0;
    inc        = 1'b0;
    dec        = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          clr        = 1'b1;
          next_state = GREEN_PASS;
        end
      end
      GREEN_PASS: begin
        if (rej_r) begin
          next_state = DONE;
        end else begin
          inc = !col_match;
          if (col == LAST_COL) next_state = YELLOW_PASS;
        end
      end
      YELLOW_PASS: begin
        dec = !green_mask[col] && hit;
        if (col == LAST_COL) next_state = DONE;
      end
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      g_r         <= '0;
      a_r         <= '0;
      col         <= '0;
      rej_r       <= 1'b0;
      green_mask  <= '0;
      guess_cnt   <= '0;
      result_r    <= '0;
      row_r       <= '0;
      done_r      <= 1'b0;
      reject_r    <= 1'b0;
      win_r       <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      done_r   <= 1'b0;
      reject_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.new_game) begin
            guess_cnt   <= '0;
            win_r       <= 1'b0;
            game_over_r <= 1'b0;
          end else if (accept) begin
            g_r        <= bus.guess;
            a_r        <= bus.answer;
            col        <= '0;
            rej_r      <= bad_letter;
            green_mask <= '0;
          end
        end
        GREEN_PASS: begin
          if (rej_r) begin
            for (int unsigned i = 0; i < NUM_COLS; i++)
              result_r[CELL_W*i +: CELL_W] <= {RED, g_r[LETTER_W*i +: LETTER_W]};
          end else begin
            result_r[CELL_W*col +: CELL_W] <= {(col_match ? GREEN : GREY), g_col};
            green_mask[col] <= col_match;
            col <= (col == LAST_COL) ? '0 : col + 3'd1;
          end
        end
        YELLOW_PASS: begin
          if (!green_mask[col])
            result_r[CELL_W*col +: CELL_W] <= {(hit ? YELLOW : GREY), g_col};
          col <= (col == LAST_COL) ? '0 : col + 3'd1;
        end
        DONE: begin
          done_r   <= 1'b1;
          reject_r <= rej_r;
          row_r    <= guess_cnt;
          if (!rej_r) begin
            guess_cnt   <= next_cnt;
            win_r       <= &green_mask;
            game_over_r <= (&green_mask) || (next_cnt == MAX_CNT);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_r;
  assign bus.row       = row_r;
  assign bus.done      = done_r;
  assign bus.reject    = reject_r;
  assign bus.win       = win_r;
  assign bus.game_over = game_over_r;

endmodule

// File: tb/tb_guess_evaluator.sv
// Scoreboard bench for guess_evaluator: stimulus pushes expected rows
// computed by a plain Wordle scoring model; a negedge monitor pops and
// compares whenever done is presented.
module tb_guess_evaluator;

  localparam int MAXG = 6;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  guess_evaluator_if bus ();

  guess_evaluator #(.MAX_GUESSES(MAXG)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [34:0] result;
    logic [2:0]  row;
    bit          chk_row;
    bit          reject;
    bit          win;
    bit          go;
    int          due;
  } exp_t;

  exp_t q[$];
  int   m_cnt = 0;
  bit   m_win = 0;
  bit   m_go  = 0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [24:0] w(input string s);
    logic [24:0] r;
    for (int i = 0; i < 5; i++) r[5*i +: 5] = 5'(s[i] - 8'd65);
    return r;
  endfunction

  function automatic logic [24:0] rand_word(input int maxl);
    logic [24:0] r;
    for (int i = 0; i < 5; i++) r[5*i +: 5] = 5'($urandom_range(maxl, 0));
    return r;
  endfunction

  function automatic logic [9:0] colors_of(input logic [34:0] r);
    logic [9:0] c;
    for (int i = 0; i < 5; i++) c[2*i +: 2] = r[7*i+5 +: 2];
    return c;
  endfunction

  // Wordle scoring: greens first, remaining answer letters form a pool that
  // the other guess letters draw from left to right.
  function automatic logic [34:0] ref_score(input logic [24:0] g, input logic [24:0] a,
                                            output bit rej, output bit allg);
    int gl[5];
    int al[5];
    int colr[5];
    int pool[26];
    logic [34:0] r;
    r = '0; rej = 0; allg = 1;
    foreach (pool[k]) pool[k] = 0;
    for (int i = 0; i < 5; i++) begin
      gl[i] = int'(g[5*i +: 5]);
      al[i] = int'(a[5*i +: 5]);
      if (gl[i] > 25) rej = 1;
    end
    for (int i = 0; i < 5; i++) begin
      if (rej) colr[i] = 3;
      else if (gl[i] == al[i]) colr[i] = 2;
      else begin colr[i] = 0; pool[al[i]]++; end
    end
    if (!rej)
      for (int i = 0; i < 5; i++)
        if (colr[i] != 2 && pool[gl[i]] > 0) begin colr[i] = 1; pool[gl[i]]--; end
    for (int i = 0; i < 5; i++) begin
      r[7*i +: 7] = {2'(colr[i]), 5'(gl[i])};
      if (colr[i] != 2) allg = 0;
    end
    return r;
  endfunction

  // Called just after a negedge; returns t = the edge that sampled submit.
  task automatic do_submit(input logic [24:0] g, input logic [24:0] a, input bit track, output int t);
    exp_t e;
    bit rej, allg;
    bus.guess = g; bus.answer = a; bus.submit = 1'b1;
    @(posedge clk); #1;
    t = cyc;
    bus.submit = 1'b0;
    if (!m_go) begin
      e.result  = ref_score(g, a, rej, allg);
      e.reject  = rej;
      e.row     = 3'(m_cnt);
      e.chk_row = !rej;
      e.due     = t + (rej ? 2 : 11);
      if (!rej) begin
        m_cnt = (m_cnt + 1 > MAXG) ? MAXG : m_cnt + 1;
        m_win = allg;
        m_go  = allg || (m_cnt == MAXG);
      end
      e.win = m_win;
      e.go  = m_go;
      if (track) q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = bus.done;
    end
    chk({name, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic start_new_game();
    bus.new_game = 1'b1;
    @(negedge clk);
    bus.new_game = 1'b0;
    m_cnt = 0; m_win = 0; m_go = 0;
    chk("new_game_win", 64'(bus.win), 64'd0);
    chk("new_game_go", 64'(bus.game_over), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_result"}, 64'(bus.result), 64'd0);
    chk({name, "_row"},    64'(bus.row), 64'd0);
    chk({name, "_busy"},   64'(bus.busy), 64'd0);
    chk({name, "_done"},   64'(bus.done), 64'd0);
    chk({name, "_reject"}, 64'(bus.reject), 64'd0);
    chk({name, "_win"},    64'(bus.win), 64'd0);
    chk({name, "_go"},     64'(bus.game_over), 64'd0);
  endtask

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 64'(bus.done), 64'd0);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("result", 64'(bus.result), 64'(e.result));
        chk("reject", 64'(bus.reject), 64'(e.reject));
        chk("win", 64'(bus.win), 64'(e.win));
        chk("game_over", 64'(bus.game_over), 64'(e.go));
        chk("busy_at_done", 64'(bus.busy), 64'd0);
        if (e.chk_row) chk("row", 64'(bus.row), 64'(e.row));
      end
    end
  end

  initial begin
    int t;
    logic [24:0] gw, aw;
    bus.new_game = 1'b0; bus.submit = 1'b0; bus.guess = '0; bus.answer = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    do_submit(w("CRANE"), w("CRANE"), 1, t);
    @(negedge clk);
    chk("busy_after_submit", 64'(bus.busy), 64'd1);
    wait_done("crane");
    chk("crane_colors", 64'(colors_of(bus.result)), 64'h2AA);
    start_new_game();

    do_submit(w("PAPAL"), w("APPLE"), 1, t);
    wait_done("papal");
    chk("papal_colors", 64'(colors_of(bus.result)), 64'h125);

    // Submitted in the cycle right after done: must be accepted.
    do_submit(w("BBBBB"), w("ABBEY"), 1, t);
    wait_done("bbbbb");
    chk("bbbbb_colors", 64'(colors_of(bus.result)), 64'h028);

    gw = w("CRANE");
    gw[14:10] = 5'd26;
    do_submit(gw, w("CRANE"), 1, t);
    wait_done("blank");
    chk("blank_colors", 64'(colors_of(bus.result)), 64'h3FF);
    chk("blank_letter2", 64'(bus.result[18:14]), 64'd26);

    start_new_game();
    aw = w("CRANE");
    for (int i = 0; i < MAXG; i++) begin
      do gw = rand_word(25); while (gw == aw);
      do_submit(gw, aw, 1, t);
      wait_done("six");
      chk("six_row", 64'(bus.row), 64'(i));
    end
    chk("six_game_over", 64'(bus.game_over), 64'd1);
    do_submit(w("CRANE"), aw, 1, t);
    repeat (3) begin
      @(negedge clk);
      chk("seventh_busy", 64'(bus.busy), 64'd0);
    end

    // new_game together with submit: new_game wins, submit dropped.
    bus.new_game = 1'b1; bus.submit = 1'b1; bus.guess = aw; bus.answer = aw;
    @(negedge clk);
    bus.new_game = 1'b0; bus.submit = 1'b0;
    m_cnt = 0; m_win = 0; m_go = 0;
    chk("ng_submit_busy", 64'(bus.busy), 64'd0);
    chk("ng_submit_go", 64'(bus.game_over), 64'd0);

    do_submit(w("PAPAL"), w("APPLE"), 0, t);
    repeat (7) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst = 1'b0;
    m_cnt = 0; m_win = 0; m_go = 0;
    do_submit(w("PAPAL"), w("APPLE"), 1, t);
    wait_done("after_rst");

    for (int n = 0; n < 30; n++) begin
      if (m_go) start_new_game();
      aw = rand_word(3);
      gw = ($urandom_range(7, 0) == 0) ? aw : rand_word(3);
      if ($urandom_range(9, 0) == 0) gw[5*$urandom_range(4, 0) +: 5] = 5'($urandom_range(31, 26));
      do_submit(gw, aw, 1, t);
      wait_done("random");
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
